// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-level arbiter sharing one TX MAC nibble stream between two sources
// Ports: clk/rst_n TX nibble clock and async active-low reset;
//        s0_*/s1_* source vld/eof/dat in, ack out; m_* MAC-side vld/eof/dat out, ack in;
//        grant one-hot registered owner; busy high in frame or idle gap;
//        frm_cnt0/frm_cnt1 wrapping counts of completed frames per source.
module eth_tx_arb #(
   parameter int GAP_CYCLES = 24,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0_vld,
   input  logic             s0_eof,
   input  logic [3:0]       s0_dat,
   output logic             s0_ack,
   input  logic             s1_vld,
   input  logic             s1_eof,
   input  logic [3:0]       s1_dat,
   output logic             s1_ack,
   output logic             m_vld,
   output logic             m_eof,
   output logic [3:0]       m_dat,
   input  logic             m_ack,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [CNT_W-1:0] frm_cnt0,
   output logic [CNT_W-1:0] frm_cnt1
);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t        state;
   logic          last;
   logic [GW-1:0] gap_cnt;
   logic          done;
   assign m_vld  = grant[0] ? s0_vld : grant[1] & s1_vld;
   assign m_eof  = grant[0] ? s0_eof : grant[1] & s1_eof;
   assign m_dat  = grant[0] ? s0_dat : grant[1] ? s1_dat : 4'h0;
   // ack only reaches a source that is actually presenting a nibble
   assign s0_ack = grant[0] & s0_vld & m_ack;
   assign s1_ack = grant[1] & s1_vld & m_ack;
   assign busy   = state != IDLE;
   assign done   = m_vld & m_ack & m_eof;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= 2'b00;
         last     <= 1'b1;
         gap_cnt  <= '0;
         frm_cnt0 <= '0;
         frm_cnt1 <= '0;
      end else
         case (state)
            IDLE: if (s0_vld | s1_vld) begin
               state <= GRANT;
               grant <= s0_vld & (~s1_vld | last) ? 2'b01 : 2'b10;
            end
            GRANT: if (done) begin
               frm_cnt0 <= frm_cnt0 + CNT_W'(grant[0]);
               frm_cnt1 <= frm_cnt1 + CNT_W'(grant[1]);
               last     <= grant[1];
               grant    <= 2'b00;
               gap_cnt  <= GW'(GAP_CYCLES);
               state    <= GAP_CYCLES > 0 ? GAP : IDLE;
            end
            GAP: begin
               state   <= gap_cnt == GW'(1) ? IDLE : GAP;
               gap_cnt <= gap_cnt - GW'(1);
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed self-checking bench for eth_tx_arb (default, GAP 5 / CNT_W 2, GAP 0)
module tb_eth_tx_arb;
   logic clk, rst_n;
   logic s0_vld, s0_eof, s1_vld, s1_eof, m_ack;
   logic [3:0] s0_dat, s1_dat;
   logic a_s0_ack, a_s1_ack, a_m_vld, a_m_eof, a_busy;
   logic [3:0] a_m_dat;
   logic [1:0] a_grant;
   logic [15:0] a_frm_cnt0, a_frm_cnt1;
   logic b_s0_ack, b_s1_ack, b_m_vld, b_m_eof, b_busy;
   logic [3:0] b_m_dat;
   logic [1:0] b_grant;
   logic [1:0] b_frm_cnt0, b_frm_cnt1;
   logic c_s0_ack, c_s1_ack, c_m_vld, c_m_eof, c_busy;
   logic [3:0] c_m_dat;
   logic [1:0] c_grant;
   logic [15:0] c_frm_cnt0, c_frm_cnt1;
   int n_chk = 0, n_err = 0;
   int bsy, ne, i0, i1, idx, st, tb, tc, f, gs[4];
   logic done, pend;
   logic [3:0] nib[3] = '{4'hA, 4'hB, 4'hC};
   int wseq[5] = '{1, 2, 3, 0, 1};

   eth_tx_arb u_a (
      .clk(clk), .rst_n(rst_n),
      .s0_vld(s0_vld), .s0_eof(s0_eof), .s0_dat(s0_dat), .s0_ack(a_s0_ack),
      .s1_vld(s1_vld), .s1_eof(s1_eof), .s1_dat(s1_dat), .s1_ack(a_s1_ack),
      .m_vld(a_m_vld), .m_eof(a_m_eof), .m_dat(a_m_dat), .m_ack(m_ack),
      .grant(a_grant), .busy(a_busy), .frm_cnt0(a_frm_cnt0), .frm_cnt1(a_frm_cnt1)
   );
   eth_tx_arb #(.GAP_CYCLES(5), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .s0_vld(s0_vld), .s0_eof(s0_eof), .s0_dat(s0_dat), .s0_ack(b_s0_ack),
      .s1_vld(s1_vld), .s1_eof(s1_eof), .s1_dat(s1_dat), .s1_ack(b_s1_ack),
      .m_vld(b_m_vld), .m_eof(b_m_eof), .m_dat(b_m_dat), .m_ack(m_ack),
      .grant(b_grant), .busy(b_busy), .frm_cnt0(b_frm_cnt0), .frm_cnt1(b_frm_cnt1)
   );
   eth_tx_arb #(.GAP_CYCLES(0)) u_c (
      .clk(clk), .rst_n(rst_n),
      .s0_vld(s0_vld), .s0_eof(s0_eof), .s0_dat(s0_dat), .s0_ack(c_s0_ack),
      .s1_vld(s1_vld), .s1_eof(s1_eof), .s1_dat(s1_dat), .s1_ack(c_s1_ack),
      .m_vld(c_m_vld), .m_eof(c_m_eof), .m_dat(c_m_dat), .m_ack(m_ack),
      .grant(c_grant), .busy(c_busy), .frm_cnt0(c_frm_cnt0), .frm_cnt1(c_frm_cnt1)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 0;
      s0_vld = 0; s0_eof = 0; s0_dat = 0;
      s1_vld = 0; s1_eof = 0; s1_dat = 0;
      m_ack = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      rst_n = 1;
      #2;
      do_reset();
      #1;
      chk("rst grant", a_grant, 0);
      chk("rst m_vld", a_m_vld, 0);
      chk("rst busy", a_busy, 0);
      chk("rst cnt0", a_frm_cnt0, 0);
      chk("rst cnt1", a_frm_cnt1, 0);
      chk("rst b grant", b_grant, 0);
      chk("rst c grant", c_grant, 0);

      // single 3-nibble frame from s0
      do_reset();
      m_ack = 1;
      @(negedge clk); s0_vld = 1; s0_dat = 4'hA; s0_eof = 0; #1;
      chk("t1 idle grant", a_grant, 0);
      chk("t1 idle m_vld", a_m_vld, 0);
      bsy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); s0_dat = nib[i]; s0_eof = (i == 2); #1;
         chk("t1 grant", a_grant, 2'b01);
         chk("t1 dat", a_m_dat, nib[i]);
         chk("t1 ack", a_s0_ack, 1);
         bsy += a_busy;
      end
      chk("t1 eof", a_m_eof, 1);
      @(negedge clk); s0_eof = 0; s0_dat = 4'h1; #1;
      chk("t1 cnt0", a_frm_cnt0, 1);
      chk("t1 cnt1", a_frm_cnt1, 0);
      chk("t1 gap grant", a_grant, 0);
      chk("t1 gap ack", a_s0_ack, 0);
      bsy += a_busy;
      for (int i = 0; i < 60 && a_busy; i++) begin
         @(negedge clk); #1;
         bsy += a_busy;
      end
      chk("t1 busy cycles", bsy, 27);
      chk("t1 idle m_vld", a_m_vld, 0);

      // contention with 2-nibble frames
      do_reset();
      m_ack = 1; i0 = 0; i1 = 0; ne = 0;
      for (int c = 0; c < 300 && ne < 4; c++) begin
         @(negedge clk);
         s0_vld = 1; s1_vld = 1;
         s0_eof = i0[0]; s1_eof = i1[0];
         s0_dat = 4'(i0); s1_dat = 4'(i1);
         #1;
         chk("t2 ungranted ack", (a_s0_ack & ~a_grant[0]) | (a_s1_ack & ~a_grant[1]), 0);
         if (a_m_vld && a_m_eof && m_ack) begin
            gs[ne] = int'(a_grant[1]);
            ne++;
         end
         if (a_s0_ack) i0++;
         if (a_s1_ack) i1++;
      end
      chk("t2 frames", ne, 4);
      for (int k = 0; k < 4; k++) chk("t2 order", gs[k], k % 2);
      @(negedge clk); s0_vld = 0; s1_vld = 0; #1;
      chk("t2 cnt0", a_frm_cnt0, 2);
      chk("t2 cnt1", a_frm_cnt1, 2);

      // gap timing, GAP 5 on u_b and GAP 0 on u_c
      do_reset();
      m_ack = 1;
      @(negedge clk); s1_vld = 1; s1_eof = 1; s1_dat = 4'h5; #1;
      @(negedge clk); #1;
      chk("t3 b xfer", b_s1_ack, 1);
      chk("t3 c xfer", c_s1_ack, 1);
      tb = 0; tc = 0;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk); #1;
         if (b_m_vld && tb == 0) tb = t;
         if (c_m_vld && tc == 0) tc = t;
      end
      chk("t3 gap5 restart", tb, 7);
      chk("t3 gap0 restart", tc, 2);

      // backpressure and mid-frame stall, s1 contending
      do_reset();
      idx = 0; st = 0; done = 0;
      @(negedge clk);
      s0_vld = 1; s0_dat = 4'h1; s0_eof = 0;
      s1_vld = 1; s1_eof = 1; s1_dat = 4'hF;
      #1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         m_ack = ~c[0];
         s0_vld = !(idx == 2 && st < 3);
         if (idx == 2 && st < 3) st++;
         s0_dat = 4'(idx + 1);
         s0_eof = (idx == 4);
         #1;
         chk("t4 grant", a_grant, 2'b01);
         chk("t4 s1 ack", a_s1_ack, 0);
         chk("t4 m_vld", a_m_vld, s0_vld);
         chk("t4 s0 ack", a_s0_ack, m_ack & s0_vld);
         if (a_s0_ack) begin
            chk("t4 nibble", a_m_dat, 4'(idx + 1));
            if (a_m_eof) done = 1;
            idx++;
         end
      end
      chk("t4 done", done, 1);
      chk("t4 count", idx, 5);
      @(negedge clk); m_ack = 1; #1;
      chk("t4 gap grant", a_grant, 0);
      chk("t4 gap s1 ack", a_s1_ack, 0);
      chk("t4 cnt0", a_frm_cnt0, 1);

      // asynchronous reset mid-frame of s1
      do_reset();
      m_ack = 1;
      @(negedge clk); s1_vld = 1; s1_dat = 4'h1; s1_eof = 0; #1;
      @(negedge clk); #1;
      chk("t5 grant", a_grant, 2'b10);
      @(negedge clk); s1_dat = 4'h2; #1;
      chk("t5 nib2", a_m_dat, 4'h2);
      rst_n = 0;
      #1;
      chk("t5 rst grant", a_grant, 0);
      chk("t5 rst m_vld", a_m_vld, 0);
      chk("t5 rst m_eof", a_m_eof, 0);
      chk("t5 rst m_dat", a_m_dat, 0);
      chk("t5 rst acks", {a_s0_ack, a_s1_ack}, 0);
      chk("t5 rst busy", a_busy, 0);
      chk("t5 rst cnt1", a_frm_cnt1, 0);
      @(negedge clk); rst_n = 1; s0_vld = 1; s0_dat = 4'h3; s0_eof = 1; #1;
      chk("t5 idle", a_grant, 0);
      @(negedge clk); #1;
      chk("t5 s0 first", a_grant, 2'b01);

      // 2-bit counter wrap on u_b
      do_reset();
      m_ack = 1; f = 0;
      @(negedge clk); s0_vld = 1; s0_eof = 1; s0_dat = 4'h7; #1;
      for (int c = 0; c < 100 && f < 5; c++) begin
         pend = b_s0_ack;
         @(negedge clk); #1;
         if (pend) begin
            chk("t6 wrap", b_frm_cnt0, wseq[f]);
            f++;
         end
      end
      chk("t6 frames", f, 5);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/eth_tx_arb.md
# eth_tx_arb

Frame-level arbiter that shares the single Ethernet TX MAC nibble stream between two frame sources, for example the key-value store response path and a future control/status responder. It runs in the `eth_tx_clk_i` domain. It grants one source at a time and holds the grant for the whole frame, through the nibble carrying `eof`. Between frames it enforces a programmable idle gap, alternates fairly under contention, and counts frames sent per source.

## Interface
Parameters:
- `GAP_CYCLES`, default 24: idle cycles forced after every frame's `eof` transfer. 0 means no gap.
- `CNT_W`, default 16: width of the per-source frame counters.

Ports:
- `clk`  in  1  TX nibble clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s0_vld`  in  1  source 0 nibble valid.
- `s0_eof`  in  1  source 0 last nibble of frame.
- `s0_dat`  in  4  source 0 nibble.
- `s0_ack`  out  1  source 0 nibble consumed.
- `s1_vld`, `s1_eof`, `s1_dat`, `s1_ack`: same as source 0, for source 1.
- `m_vld`  out  1  valid toward the MAC (`tx_vld`).
- `m_eof`  out  1  eof toward the MAC (`tx_eof`).
- `m_dat`  out  4  nibble toward the MAC (`tx_dat`).
- `m_ack`  in  1  MAC consumed nibble (`tx_ack`).
- `grant`  out  2  one-hot registered grant. 00 means none.
- `busy`  out  1  high in GRANT or GAP.
- `frm_cnt0`  out  CNT_W  frames completed from source 0.
- `frm_cnt1`  out  CNT_W  frames completed from source 1.

## Operation
Handshake, on every interface:
- A nibble transfers on a cycle where vld and ack are both high.
- A source holds `dat` and `eof` stable while vld is high and ack is low.

States and transitions:
- **IDLE.** `grant` = 00 and `m_vld` = 0.
  - If exactly one `sN_vld` is high, go to GRANT with `grant[N]` = 1.
  - If both are high, grant the source that is not `last`.
  - `last` resets to 1, so source 0 wins the first contention.
- **GRANT.** Datapath is combinational from the granted source.
  - `m_vld`/`m_eof`/`m_dat` = `sN_vld`/`sN_eof`/`sN_dat`.
  - `sN_ack` = `m_ack`. The ungranted source's ack is 0.
  - On `m_vld & m_ack & m_eof`:
    - `frm_cntN` increments.
    - `last` <= N.
    - `grant` <= 00.
    - Next state is GAP if `GAP_CYCLES` > 0, else IDLE.
- **GAP.** A down-counter loads `GAP_CYCLES` on entry. Outputs are as in IDLE.
  - Return to IDLE on the cycle the counter reaches 1.
  - Requests arriving during GAP wait; they are not acked.

Boundary behaviour:
- **Granted source drops `vld` mid-frame:** grant is held and `m_vld` follows low. There is no timeout; underrun handling belongs to the MAC.
- **`m_ack` while `m_vld` is low:** ignored, and no ack is forwarded.
- **Single-nibble frame** (`eof` on the first nibble): legal. The counter increments once.
- **Frame counters:** wrap modulo 2^CNT_W with no saturation.
- **Asynchronous reset mid-frame:** immediately forces IDLE, `grant` = 00, `m_vld` = 0, both acks 0, `last` = 1, counters 0, gap counter 0. The truncated frame is not counted.
- **Reset values:** every output is 0.

## Timing
- **Grant latency:** a request first seen in IDLE at cycle n gives `grant` registered at n+1. `m_vld` can be high at n+1, and the first transfer can occur at n+1.
- **Data latency:** zero-cycle pass-through within GRANT. There are no data registers; the output registers sit in the MAC/IOB stage.
- **Gap:** `eof` transfers at cycle k. GAP occupies k+1 … k+GAP_CYCLES, IDLE is at k+GAP_CYCLES+1, and the earliest next grant is k+GAP_CYCLES+2.
- **Gap with `GAP_CYCLES` = 0:** IDLE at k+1, next grant at k+2.
- **Throughput:** 1 nibble/cycle while `m_ack` is held high.

## Test plan
- **Single frame:** `s0` sends 3 nibbles 0xA, 0xB, 0xC with `eof` on 0xC, and `m_ack` is held 1.
  - `m_dat` shows A, B, C at n+1 … n+3.
  - `frm_cnt0` = 1 and `frm_cnt1` = 0.
  - `busy` stays high for 3 + 24 cycles.
- **Contention:** both sources request continuously with 2-nibble frames.
  - Grants go `s0`, `s1`, `s0`, `s1`.
  - After 4 frames, `frm_cnt0` = `frm_cnt1` = 2.
  - The ungranted ack is never high.
- **Gap timing:** `GAP_CYCLES` = 5, and `s1` is ready again immediately after its `eof` at cycle k.
  - Next `m_vld` is at exactly k+7.
  - With `GAP_CYCLES` = 0, next `m_vld` is at k+2.
- **Backpressure and stall:** `m_ack` toggles 1,0,1,0, and `s0_vld` drops for 3 cycles mid-frame.
  - Nibbles arrive in order with no duplicates or losses.
  - `grant` stays 01 and `s1` is not served until `s0`'s `eof`.
- **Reset mid-frame:** `rst_n` low during nibble 2 of a `s1` frame.
  - All outputs are 0 in the same cycle, and `frm_cnt1` = 0.
  - After release, a fresh `s0` request is granted first because `last` = 1.
- **Counter wrap:** `CNT_W` = 2 with 5 frames on `s0`.
  - `frm_cnt0` sequence is 1, 2, 3, 0, 1.
